tiny_nn_result_collector: RTL and testbench

- Downstream stage of the convolve engine.
- Consumes the engine's 8-bit output byte stream (low byte then high byte per result) and reassembles 16-bit fp_t accumulate results.
- Discards the configured number of pipeline warm-up results at the start of each run.
- Buffers results in a small show-ahead FIFO with a valid/ready output to the host-side reader.

---
 rtl/tiny_nn_result_collector.sv | 121 ++++++++++++
 tb/tb_tiny_nn_result_collector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tiny_nn_result_collector.sv
// Reassembles the convolve engine's low/high byte stream into 16-bit results,
// drops the warm-up pairs of each frame, and queues results in a show-ahead FIFO.
module tiny_nn_result_collector #(
  parameter int DepthLog2 = 3,
  parameter int SkipPairs = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  input  logic                 frame_end_i,
  output logic                 result_valid_o,
  output logic [15:0]          result_o,
  input  logic                 result_ready_i,
  output logic [DepthLog2:0]   level_o,
  output logic                 overflow_o
);

  localparam int Depth = 1 << DepthLog2;
  localparam int SkipW = (SkipPairs > 0) ? $clog2(SkipPairs + 1) : 1;
  localparam logic [SkipW-1:0] SkipInit = SkipW'(SkipPairs);
  localparam logic [DepthLog2:0] LevelFull = (DepthLog2 + 1)'(Depth);

  typedef enum logic [1:0] {SKIP_LOW, SKIP_HIGH, CAP_LOW, CAP_HIGH} state_e;
  localparam state_e StateInit = (SkipPairs == 0) ? CAP_LOW : SKIP_LOW;

  state_e               state_q, state_d;
  logic [SkipW-1:0]     skip_q, skip_d, skip_dec;
  logic [7:0]           lo_q, lo_d;
  logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DepthLog2:0]   level_q, level_d;
  logic                 overflow_q;
  logic [15:0]          mem_q [Depth];

  logic        push, push_ok, pop, overflow_set;
  logic [15:0] push_data;

  // Alignment FSM; frame_end overrides whatever the byte in that cycle did.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    lo_d      = lo_q;
    push      = 1'b0;
    push_data = {byte_i, lo_q};
    skip_dec  = skip_q - 1'b1;
    if (byte_valid_i) begin
      case (state_q)
        SKIP_LOW:  state_d = SKIP_HIGH;
        SKIP_HIGH: begin
          skip_d  = skip_dec;
          state_d = (skip_dec == '0) ? CAP_LOW : SKIP_LOW;
        end
        CAP_LOW: begin
          lo_d    = byte_i;
          state_d = CAP_HIGH;
        end
        CAP_HIGH: begin
          push    = 1'b1;
          state_d = CAP_LOW;
        end
        default:   state_d = StateInit;
      endcase
    end
    if (frame_end_i) begin
      state_d = StateInit;
      skip_d  = SkipInit;
    end
  end

  // A pop frees the slot, so a push into a full FIFO is still accepted then.
  always_comb begin
    pop          = (level_q != '0) && result_ready_i;
    push_ok      = push && ((level_q != LevelFull) || pop);
    overflow_set = push && !push_ok;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d     = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d      = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StateInit;
      skip_q     <= SkipInit;
      lo_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      state_q    <= StateInit;
      skip_q     <= SkipInit;
      lo_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      lo_q       <= lo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_q | overflow_set;
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign result_valid_o = (level_q != '0);
  assign result_o       = mem_q[rd_ptr_q];
  assign level_o        = level_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_tiny_nn_result_collector.sv
// Drives three collectors (SkipPairs = 0, 1, 2) with one byte stream and checks
// each against a byte-index / unbounded-queue reference model.
module tb_tiny_nn_result_collector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_d = 8'h00;
  logic frame_end = 1'b0;
  logic ready = 1'b0;

  logic [2:0]       rv;
  logic [2:0][15:0] ro;
  logic [2:0][3:0]  lvl;
  logic [2:0]       ovf;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    tiny_nn_result_collector #(.DepthLog2(3), .SkipPairs(gi)) u_dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear),
      .byte_valid_i(byte_valid), .byte_i(byte_d), .frame_end_i(frame_end),
      .result_valid_o(rv[gi]), .result_o(ro[gi]), .result_ready_i(ready),
      .level_o(lvl[gi]), .overflow_o(ovf[gi])
    );
  end

  // Reference model: results are pairs at byte positions >= 2*skip in the frame.
  int          midx  [3];
  logic [7:0]  mlo   [3];
  logic [15:0] mbuf  [3][4096];
  int          mhead [3];
  int          mtail [3];
  logic        movf  [3];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s skip=%0d: got %h expected %h", tag, k, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      midx[k] = 0; mlo[k] = 8'h00; mhead[k] = 0; mtail[k] = 0; movf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic clr, input logic bv, input logic [7:0] b,
                            input logic fe, input logic rdy);
    int size, pos;
    logic do_push, do_pop;
    logic [15:0] val;
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        midx[k] = 0; mhead[k] = 0; mtail[k] = 0; movf[k] = 1'b0;
      end else begin
        size = mtail[k] - mhead[k];
        do_pop = (size > 0) && rdy;
        do_push = 1'b0;
        val = 16'h0;
        if (bv) begin
          pos = midx[k] - 2 * k;
          if (pos >= 0) begin
            if (pos % 2 == 0) mlo[k] = b;
            else begin
              do_push = 1'b1;
              val = {b, mlo[k]};
            end
          end
          midx[k]++;
        end
        if (do_pop) mhead[k]++;
        if (do_push) begin
          if (size < 8 || do_pop) begin
            mbuf[k][mtail[k]] = val;
            mtail[k]++;
          end else movf[k] = 1'b1;
        end
        if (fe) midx[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    int size;
    for (int k = 0; k < 3; k++) begin
      size = mtail[k] - mhead[k];
      chk("valid", k, 32'(rv[k]), 32'(size > 0));
      chk("level", k, 32'(lvl[k]), 32'(size));
      chk("overflow", k, 32'(ovf[k]), 32'(movf[k]));
      if (size > 0) chk("result", k, 32'(ro[k]), 32'(mbuf[k][mhead[k]]));
    end
  endtask

  task automatic step(input logic clr, input logic bv, input logic [7:0] b,
                      input logic fe, input logic rdy);
    clear = clr; byte_valid = bv; byte_d = b; frame_end = fe; ready = rdy;
    model_step(clr, bv, b, fe, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send_pair(input logic [15:0] w, input logic rdy);
    step(1'b0, 1'b1, w[7:0], 1'b0, rdy);
    step(1'b0, 1'b1, w[15:8], 1'b0, rdy);
  endtask

  // Asynchronous reset checked between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    for (int k = 0; k < 3; k++) chk("result_rst", k, 32'(ro[k]), 32'h0);
    rst = 1'b0;
  endtask

  logic [7:0] seq8 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h3C, 8'hCD, 8'hAB};

  initial begin
    #1;
    do_reset();

    // Warm-up skip then capture with the reader always ready.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, seq8[i], 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Gapped pair.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill past full, then drain.
    for (int i = 1; i <= 11; i++) send_pair(16'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Full FIFO with simultaneous pop and push, exercising pointer wrap.
    for (int i = 1; i <= 10; i++) send_pair(16'(16'h0100 + i), 1'b0);
    step(1'b0, 1'b1, 8'h34, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h12, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Frame end after a lone low byte, then a new frame.
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h06, 1'b0, 1'b0);

    // Overflow then clear with a byte in flight.
    for (int i = 0; i < 10; i++) send_pair(16'($urandom), 1'b0);
    step(1'b0, 1'b1, 8'h9A, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h9B, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-pair.
    for (int i = 0; i < 4; i++) send_pair(16'($urandom), 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);

    // Randomized traffic with alternating reader pressure.
    for (int i = 0; i < 1500; i++) begin
      logic clr, bv, fe, rdy;
      clr = ($urandom_range(99) == 0);
      bv  = ($urandom_range(9) < 6);
      fe  = ($urandom_range(39) == 0);
      rdy = ((i / 100) % 2 == 1) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
      if ($urandom_range(299) == 0) do_reset();
      step(clr, bv, 8'($urandom), fe, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
